seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000; clk cycles per digit slot (1 ms at 100 MHz), legal >= 2.
REQ-002 SHALL have parameter BLINK_DIV, default 50_000_000; clk cycles per blink half-period, legal >= 2.
REQ-003 clk  input  1  system clock, single clock domain, all state on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 time_data  input  32  eight 4-bit digit codes; [31:28] = leftmost digit 7, [3:0] = rightmost digit 0.
REQ-006 blink_en  input  1  enables blinking of digits selected by blink_mask.
REQ-007 blink_mask  input  8  bit k = 1 marks digit k as blinking.
REQ-008 digit1  output  8  segments {a,b,c,d,e,f,g,dp}, active-high, for left group (digits 7..4).
REQ-009 digit2  output  8  same encoding, for right group (digits 3..0).
REQ-010 tube_sel  output  8  one-hot active-high digit enable, bit k = digit k.

Function
REQ-011 Digit code map SHALL be: 0-9 -> decimal glyph, dp off; 4'hF -> dash (g only); 4'hA-4'hE -> blank (all segments off).
REQ-012 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; the wrap cycle is the scan tick.
REQ-013 Index register idx (3 bits, reset 0) SHALL increment modulo 8 on each scan tick, 7 -> 0 wrapping.
REQ-014 On a scan tick with idx = 0, a 32-bit snapshot SHALL load time_data; all eight digits of one frame SHALL come from that one snapshot (no tearing).
REQ-015 On each scan tick the outputs SHALL register: tube_sel = 1 << idx; the active group bus = glyph of digit idx; the other group bus = 8'h00.
REQ-016 Digit 0's glyph SHALL be decoded from live time_data (same value loaded into the snapshot); digits 1-7 from the snapshot.
REQ-017 Outputs SHALL hold constant between scan ticks; latency from scan tick to new output = 1 clk (registered).
REQ-018 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase at wrap; blink_phase reset value 1 (visible).
REQ-019 While blink_en = 0, blink counter SHALL be held at 0 and blink_phase forced to 1.
REQ-020 When blink_phase = 0 and blink_mask[idx] = 1 at a scan tick, the emitted glyph SHALL be blank; tube_sel still advances.
REQ-021 blink_mask and blink_en SHALL be sampled live at each scan tick, not snapshotted.
REQ-022 Exactly one tube_sel bit SHALL be high after the first scan tick; at most one of digit1/digit2 SHALL be non-zero at any time.

Reset
REQ-023 rst low SHALL asynchronously clear: prescaler 0, idx 0, snapshot 0, blink counter 0, blink_phase 1, digit1 = digit2 = tube_sel = 8'h00.
REQ-024 Outputs SHALL remain 8'h00 after reset release until the first scan tick, which SHALL display digit 0 and load the snapshot.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL restart at digit 0 with a fresh snapshot.

Configuration
REQ-026 Macro SEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero suppression.
REQ-027 With it defined: digit k (k = 7..1) SHALL be blank when its code is 0 and every higher digit's code is 0 or 4'hA-4'hE; digit 0 SHALL never be suppressed; 4'hF stops suppression.
REQ-028 Without it: zeros SHALL always display as "0"; no suppression logic present.

Verification (bench uses SCAN_DIV = 4, BLINK_DIV = 16)
REQ-029 Reset release, time_data = 32'h00F03F25 -> outputs 0 for 3 clk; then tube_sel 01,02,...,80 every 4 clk; digit2 shows 5,2,dash,3; digit1 shows 0,dash,0,0 (macro off).
REQ-030 Same data with SEG_LEADING_ZERO_BLANK_EN -> digits 7,6 blank (8'h00 on digit1), digit 5 dash, digit 4 "0".
REQ-031 Change time_data while idx = 3 -> digits 3..7 of current frame keep old values; new values appear from next digit-0 slot.
REQ-032 blink_en = 1, blink_mask = 8'h03 -> digits 0,1 blank for alternating 16-clk windows; other digits unaffected; blink_en = 0 -> digits 0,1 steady.
REQ-033 Assert rst while idx = 5 -> all outputs 8'h00 immediately (async); after release first non-zero tube_sel = 8'h01.
REQ-034 time_data = 32'hABCDE987 -> digits 7..3 blank, digits 2..0 show 9,8,7; one-hot tube_sel checked every cycle.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - digit data, blink control and segment/tube outputs of seg_scan_driver
interface seg_scan_driver_if;
  logic [31:0] time_data;
  logic        blink_en;
  logic [7:0]  blink_mask;
  logic [7:0]  digit1;
  logic [7:0]  digit2;
  logic [7:0]  tube_sel;

  // Driver of digit data and consumer of the display lines
  modport master (
    output time_data, blink_en, blink_mask,
    input  digit1, digit2, tube_sel
  );

  // The scan driver itself
  modport slave (
    input  time_data, blink_en, blink_mask,
    output digit1, digit2, tube_sel
  );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed 7-segment scan driver with blink; SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  logic [SW-1:0] presc_q;
  logic [2:0]    idx_q;
  // Digit 0 is always taken live, so only digits 7..1 are held
  logic [31:4]   snap_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [7:0]    digit1_q;
  logic [7:0]    digit2_q;
  logic [7:0]    tube_sel_q;

  logic          scan_tick;
  logic [31:0]   frame_data;
  logic [3:0]    code;
  logic [7:0]    glyph_d;

  assign scan_tick  = (presc_q == SW'(SCAN_DIV - 1));
  assign frame_data = {snap_q, bus.time_data[3:0]};

  function automatic logic [7:0] seg_decode(input logic [3:0] c);
    case (c)
      4'h0:    seg_decode = 8'hFC;
      4'h1:    seg_decode = 8'h60;
      4'h2:    seg_decode = 8'hDA;
      4'h3:    seg_decode = 8'hF2;
      4'h4:    seg_decode = 8'h66;
      4'h5:    seg_decode = 8'hB6;
      4'h6:    seg_decode = 8'hBE;
      4'h7:    seg_decode = 8'hE0;
      4'h8:    seg_decode = 8'hFE;
      4'h9:    seg_decode = 8'hF6;
      4'hF:    seg_decode = 8'h02;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  // Scan prescaler: wraps every SCAN_DIV cycles, the wrap cycle is the scan tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           presc_q <= '0;
    else if (scan_tick) presc_q <= '0;
    else                presc_q <= presc_q + SW'(1);
  end

  // Digit index advances per tick; the frame snapshot is taken on the digit-0 tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= 3'd0;
      snap_q <= '0;
    end else if (scan_tick) begin
      idx_q <= idx_q + 3'd1;
      if (idx_q == 3'd0) snap_q <= bus.time_data[31:4];
    end
  end

  // Blink half-period counter; idle (visible phase) whenever blinking is disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (!bus.blink_en) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Glyph for the digit being scanned, after leading-zero and blink blanking
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic lead_zero;
  logic higher_dark;
`endif
  always_comb begin
    code    = frame_data[{idx_q, 2'b00} +: 4];
    glyph_d = seg_decode(code);
`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A zero is blanked only while every digit to its left is zero or blank
    lead_zero   = 1'b0;
    higher_dark = 1'b1;
    for (int j = 7; j >= 1; j--) begin
      if (j == int'(idx_q)) lead_zero = higher_dark && (frame_data[4*j +: 4] == 4'h0);
      if (!((frame_data[4*j +: 4] == 4'h0) ||
            ((frame_data[4*j +: 4] >= 4'hA) && (frame_data[4*j +: 4] <= 4'hE))))
        higher_dark = 1'b0;
    end
    if (lead_zero) glyph_d = 8'h00;
`endif
    if (bus.blink_en && !blink_phase_q && bus.blink_mask[idx_q]) glyph_d = 8'h00;
  end

  // Registered display outputs, updated only on scan ticks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit1_q   <= 8'h00;
      digit2_q   <= 8'h00;
      tube_sel_q <= 8'h00;
    end else if (scan_tick) begin
      tube_sel_q <= 8'h01 << idx_q;
      if (idx_q[2]) begin
        digit1_q <= glyph_d;
        digit2_q <= 8'h00;
      end else begin
        digit1_q <= 8'h00;
        digit2_q <= glyph_d;
      end
    end
  end

  assign bus.digit1   = digit1_q;
  assign bus.digit2   = digit2_q;
  assign bus.tube_sel = tube_sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  seg_scan_driver_if bus ();

  seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Glyphs {a,b,c,d,e,f,g,dp} indexed by digit code
  logic [7:0] segs [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                            8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic lead_blank(input logic [31:0] d, input int k);
    logic [3:0] c;
    if (k == 0 || d[4*k +: 4] != 4'h0) return 1'b0;
    for (int j = k + 1; j < 8; j++) begin
      c = d[4*j +: 4];
      if ((c >= 4'h1 && c <= 4'h9) || c == 4'hF) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected glyph for the tick at edge n (0-based since reset), e enabled edges so far
  function automatic logic [7:0] ref_slot(input int n, input logic [31:0] snap, input logic [31:0] data,
                                          input logic en, input logic [7:0] mask, input int e);
    int k;
    logic [31:0] frame;
    logic [7:0] g;
    k     = (n / SCAN_DIV) % 8;
    frame = (k == 0) ? data : snap;
    g     = segs[frame[4*k +: 4]];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (lead_blank(frame, k)) g = 8'h00;
`endif
    if (en && ((e / BLINK_DIV) % 2 == 1) && mask[k]) g = 8'h00;
    return g;
  endfunction

  // Reference model: slot numbering and blink phase derived from edge counts
  int          m_n = 0;
  int          m_e = 0;
  logic [31:0] m_snap = '0;
  logic [7:0]  e_t = '0, e_d1 = '0, e_d2 = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_n <= 0; m_e <= 0; m_snap <= '0;
      e_t <= '0; e_d1 <= '0; e_d2 <= '0;
    end else begin
      m_n <= m_n + 1;
      m_e <= bus.blink_en ? m_e + 1 : 0;
      if (m_n % SCAN_DIV == SCAN_DIV - 1) begin
        e_t <= 8'h01 << ((m_n / SCAN_DIV) % 8);
        if ((m_n / SCAN_DIV) % 8 < 4) begin
          e_d2 <= ref_slot(m_n, m_snap, bus.time_data, bus.blink_en, bus.blink_mask, m_e);
          e_d1 <= 8'h00;
        end else begin
          e_d1 <= ref_slot(m_n, m_snap, bus.time_data, bus.blink_en, bus.blink_mask, m_e);
          e_d2 <= 8'h00;
        end
        if ((m_n / SCAN_DIV) % 8 == 0) m_snap <= bus.time_data;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      chk("model tube_sel", bus.tube_sel, e_t);
      chk("model digit1", bus.digit1, e_d1);
      chk("model digit2", bus.digit2, e_d2);
      chk("tube_sel at most one-hot", 32'($countones(bus.tube_sel) <= 1), 32'd1);
      chk("single active group", 32'(!(bus.digit1 != 8'h00 && bus.digit2 != 8'h00)), 32'd1);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Checks zeros until the first tick, then all eight slots against exp {d7..d0}
  task automatic run_frame(input logic [63:0] exp, input string tag);
    for (int e = 1; e < SCAN_DIV; e++) begin
      @(posedge clk); #1;
      chk($sformatf("%s pre-tick tube_sel", tag), bus.tube_sel, 8'h00);
      chk($sformatf("%s pre-tick digits", tag), {bus.digit1, bus.digit2}, 16'h0000);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 0) @(posedge clk);
      else repeat (SCAN_DIV) @(posedge clk);
      #1;
      chk($sformatf("%s slot%0d tube_sel", tag, k), bus.tube_sel, 8'h01 << k);
      if (k < 4) begin
        chk($sformatf("%s slot%0d digit2", tag, k), bus.digit2, exp[8*k +: 8]);
        chk($sformatf("%s slot%0d digit1", tag, k), bus.digit1, 8'h00);
      end else begin
        chk($sformatf("%s slot%0d digit1", tag, k), bus.digit1, exp[8*k +: 8]);
        chk($sformatf("%s slot%0d digit2", tag, k), bus.digit2, 8'h00);
      end
    end
  endtask

  task automatic check_slot(input int k, input logic [7:0] g, input string tag);
    #1;
    chk($sformatf("%s tube_sel", tag), bus.tube_sel, 8'h01 << k);
    chk($sformatf("%s glyph", tag), (k < 4) ? bus.digit2 : bus.digit1, g);
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       d[4*i +: 4] = 4'h0;
        1:       d[4*i +: 4] = 4'($urandom_range(10, 15));
        default: d[4*i +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return d;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic [63:0] exp_off;
    logic [63:0] exp_on;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{32'h00F03F25, 64'hFCFC02FCF202DAB6, 64'h000002FCF202DAB6};
    vecs[1] = '{32'hABCDE987, 64'h0000000000F6FEE0, 64'h0000000000F6FEE0};
    vecs[2] = '{32'h00000000, 64'hFCFCFCFCFCFCFCFC, 64'h00000000000000FC};
    vecs[3] = '{32'h01234567, 64'hFC60DAF266B6BEE0, 64'h0060DAF266B6BEE0};
    vecs[4] = '{32'h0A0B0C01, 64'hFC00FC00FC00FC60, 64'h0000000000000060};

    bus.time_data  = '0;
    bus.blink_en   = 1'b0;
    bus.blink_mask = '0;

    for (int i = 0; i < 5; i++) begin
      bus.time_data = vecs[i].data;
      do_reset();
      run_frame(LZ ? vecs[i].exp_on : vecs[i].exp_off, $sformatf("vec%0d", i));
    end

    // Data changed mid-frame: rest of frame keeps the old snapshot
    bus.time_data = 32'h76543210;
    do_reset();
    repeat (3 * SCAN_DIV) @(posedge clk);
    @(negedge clk);
    bus.time_data = 32'h11111111;
    repeat (SCAN_DIV) @(posedge clk); check_slot(3, 8'hF2, "tear d3");
    repeat (SCAN_DIV) @(posedge clk); check_slot(4, 8'h66, "tear d4");
    repeat (SCAN_DIV) @(posedge clk); check_slot(5, 8'hB6, "tear d5");
    repeat (SCAN_DIV) @(posedge clk); check_slot(6, 8'hBE, "tear d6");
    repeat (SCAN_DIV) @(posedge clk); check_slot(7, 8'hE0, "tear d7");
    repeat (SCAN_DIV) @(posedge clk); check_slot(0, 8'h60, "new d0");
    repeat (SCAN_DIV) @(posedge clk); check_slot(1, 8'h60, "new d1");

    // Blink on digits 0,1, enabled just before edge 16 so frame 2 hits the dark phase
    bus.time_data  = 32'h77777721;
    bus.blink_mask = 8'h03;
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    bus.blink_en = 1'b1;
    repeat (21) @(posedge clk);     check_slot(0, 8'h00, "blink d0 dark");
    repeat (SCAN_DIV) @(posedge clk); check_slot(1, 8'h00, "blink d1 dark");
    repeat (SCAN_DIV) @(posedge clk); check_slot(2, 8'hE0, "blink d2 unmasked");
    @(negedge clk);
    bus.blink_en = 1'b0;
    repeat (24) @(posedge clk);     check_slot(0, 8'h60, "blink off d0");
    repeat (SCAN_DIV) @(posedge clk); check_slot(1, 8'hDA, "blink off d1");
    bus.blink_mask = 8'h00;

    // Asynchronous reset in the middle of slot 5
    bus.time_data = 32'h87654321;
    do_reset();
    repeat (5 * SCAN_DIV + 2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst tube_sel", bus.tube_sel, 8'h00);
    chk("async rst digit1", bus.digit1, 8'h00);
    chk("async rst digit2", bus.digit2, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    run_frame(64'hFEE0BEB666F2DA60, "after rst");

    // Randomised run against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0)   bus.time_data  = rand_data();
      if ($urandom_range(0, 99) == 0)   bus.blink_en   = ~bus.blink_en;
      if ($urandom_range(0, 199) == 0)  bus.blink_mask = 8'($urandom);
      if ($urandom_range(0, 1499) == 0) do_reset();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
